mod_mult_barrett_sched_64b: RTL

//  Shares one pipelined 64b Barrett modular multiplier (mod_multiplier_barrett_64b, instantiated

---
 rtl/mod_mult_barrett_sched_64b.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mod_mult_barrett_sched_64b.sv
// Round-robin scheduler sharing one pipelined 64b Barrett modular multiplier
// between NUM_REQ requesters. Requester tags travel alongside the pipe in a
// valid/tag shift register kept in lock-step with the multiplier through a
// common enable; output back-pressure freezes the whole pipe.
//
// Handshakes: a request transfers on a rising edge where iReqValid[r] and
// oReqRdy[r] are both high; a result transfers where oValid and iRdy are both
// high; a config write transfers where iCfgWe and oCfgRdy are both high.
// oValid/oTag/oData never change while oValid is high and iRdy is low.
//
// Optional feature macro: MOD_MULT_SCHED_PERF_EN adds oIssueCnt/oStallCnt.

// Barrett multiplier, k = 64: q = ((x >> 63) * U) >> 65 underestimates
// floor(x/M) by at most 2, so two conditional subtracts finish the reduction.
// Pipeline depth is exactly LATENCY enabled cycles (stages 1-5 compute,
// the rest are alignment delay).
module mod_multiplier_barrett_64b #(
  parameter int LATENCY = 10
) (
  input  logic          iClk,
  input  logic          iRstN,
  input  logic          iClr,
  input  logic          iEn,
  input  logic [63:0]   iA,
  input  logic [63:0]   iB,
  input  logic [63:0]   iMod,
  input  logic [127:0]  iU,
  output logic [63:0]   oData
);
  localparam int DLY = LATENCY - 5;

  logic [127:0] s1_p;
  logic [65:0]  s2_q;
  logic [65:0]  s2_plo;
  logic [65:0]  s3_r;
  logic [65:0]  s4_r;
  logic [63:0]  s5_r;
  logic [63:0]  dly [DLY];

  // Compute stages plus alignment delay, all frozen together by iEn
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      s1_p   <= '0;
      s2_q   <= '0;
      s2_plo <= '0;
      s3_r   <= '0;
      s4_r   <= '0;
      s5_r   <= '0;
      for (int i = 0; i < DLY; i++) dly[i] <= '0;
    end else if (iClr) begin
      s1_p   <= '0;
      s2_q   <= '0;
      s2_plo <= '0;
      s3_r   <= '0;
      s4_r   <= '0;
      s5_r   <= '0;
      for (int i = 0; i < DLY; i++) dly[i] <= '0;
    end else if (iEn) begin
      s1_p   <= {64'b0, iA} * {64'b0, iB};
      s2_q   <= 66'(({128'b0, s1_p[127:63]} * {65'b0, iU}) >> 65);
      // true remainder is < 3M < 2^66, so 66-bit wraparound arithmetic is exact
      s2_plo <= s1_p[65:0];
      s3_r   <= s2_plo - ({2'b0, iMod} * s2_q);
      s4_r   <= (s3_r >= {2'b0, iMod}) ? (s3_r - {2'b0, iMod}) : s3_r;
      s5_r   <= (s4_r >= {2'b0, iMod}) ? 64'(s4_r - {2'b0, iMod}) : s4_r[63:0];
      dly[0] <= s5_r;
      for (int i = 1; i < DLY; i++) dly[i] <= dly[i-1];
    end
  end

  assign oData = dly[DLY-1];
endmodule

module mod_mult_barrett_sched_64b #(
  parameter int NUM_REQ = 4,
  parameter int TAG_W   = 2,
  parameter int LATENCY = 10
) (
  input  logic                  iClk,
  input  logic                  iRstN,
  input  logic                  iClr,
  input  logic                  iCfgWe,
  input  logic [63:0]           iCfgMod,
  input  logic [127:0]          iCfgU,
  output logic                  oCfgRdy,
  input  logic [NUM_REQ-1:0]    iReqValid,
  input  logic [NUM_REQ*64-1:0] iReqData0,
  input  logic [NUM_REQ*64-1:0] iReqData1,
  output logic [NUM_REQ-1:0]    oReqRdy,
  output logic                  oValid,
  output logic [63:0]           oData,
  output logic [TAG_W-1:0]      oTag,
  input  logic                  iRdy,
  output logic                  oBusy
`ifdef MOD_MULT_SCHED_PERF_EN
  , output logic [31:0]         oIssueCnt
  , output logic [31:0]         oStallCnt
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t             state;
  logic [TAG_W-1:0]   ptr;
  logic [LATENCY-1:0] vld_sr;
  logic [TAG_W-1:0]   tag_sr [LATENCY];
  logic [63:0]        cfg_mod;
  logic [127:0]       cfg_u;
  logic               cfg_loaded;

  logic               en;
  logic               grant_ok;
  logic               found;
  logic [TAG_W-1:0]   gidx;
  logic               grant;
  logic               cfg_take;
  logic               pipe_empty;
  logic [63:0]        mul_a;
  logic [63:0]        mul_b;

  assign en         = ~(oValid & ~iRdy);
  assign pipe_empty = ~|vld_sr;
  // A pending config write blocks grants so config always wins the cycle
  assign grant_ok   = ~iClr & en & ~iCfgWe &
                      ((state == RUN) | ((state == IDLE) & cfg_loaded));
  assign grant      = found & grant_ok;
  assign cfg_take   = iCfgWe & ~iClr & ((state == IDLE) | ((state == DRAIN) & pipe_empty));
  assign oCfgRdy    = cfg_take;
  assign oReqRdy    = grant ? (NUM_REQ'(1) << gidx) : '0;
  assign oValid     = vld_sr[LATENCY-1];
  assign oTag       = tag_sr[LATENCY-1];
  assign oBusy      = (state != IDLE) | ~pipe_empty;

  // Round-robin search: first valid requester at or after ptr, wrapping
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    gidx  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (!found && iReqValid[TAG_W'(idx)]) begin
        found = 1'b1;
        gidx  = TAG_W'(idx);
      end
    end
  end

  // Operand mux; idle slots feed zeros so the pipe carries a zero result
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (oReqRdy[r]) begin
        mul_a = iReqData0[r*64 +: 64];
        mul_b = iReqData1[r*64 +: 64];
      end
    end
  end

  // Scheduler state, pointer, valid/tag shift registers and config registers
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      state      <= IDLE;
      ptr        <= '0;
      vld_sr     <= '0;
      for (int i = 0; i < LATENCY; i++) tag_sr[i] <= '0;
      cfg_mod    <= '0;
      cfg_u      <= '0;
      cfg_loaded <= 1'b0;
    end else if (iClr) begin
      // config registers deliberately survive a clear
      state  <= IDLE;
      ptr    <= '0;
      vld_sr <= '0;
      for (int i = 0; i < LATENCY; i++) tag_sr[i] <= '0;
    end else begin
      if (cfg_take) begin
        cfg_mod    <= iCfgMod;
        cfg_u      <= iCfgU;
        cfg_loaded <= 1'b1;
      end
      if (en) begin
        vld_sr    <= {vld_sr[LATENCY-2:0], grant};
        tag_sr[0] <= grant ? gidx : '0;
        for (int i = 1; i < LATENCY; i++) tag_sr[i] <= tag_sr[i-1];
      end
      if (grant) ptr <= TAG_W'((int'(gidx) + 1) % NUM_REQ);
      case (state)
        IDLE:    if (grant) state <= RUN;
        RUN: begin
          if (iCfgWe)                     state <= DRAIN;
          else if (!grant && pipe_empty)  state <= IDLE;
        end
        DRAIN:   if (cfg_take) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mod_multiplier_barrett_64b #(.LATENCY(LATENCY)) u_mul (
    .iClk  (iClk),
    .iRstN (iRstN),
    .iClr  (iClr),
    .iEn   (en),
    .iA    (mul_a),
    .iB    (mul_b),
    .iMod  (cfg_mod),
    .iU    (cfg_u),
    .oData (oData)
  );

`ifdef MOD_MULT_SCHED_PERF_EN
  // Issue and stall counters, free-running with natural 32-bit wrap
  always_ff @(posedge iClk or negedge iRstN) begin
    if (!iRstN) begin
      oIssueCnt <= '0;
      oStallCnt <= '0;
    end else if (iClr) begin
      oIssueCnt <= '0;
      oStallCnt <= '0;
    end else begin
      if (grant) oIssueCnt <= oIssueCnt + 32'd1;
      if (!en)   oStallCnt <= oStallCnt + 32'd1;
    end
  end
`endif
endmodule
